// File: rtl/dfp_pkg.sv
// dfp_pkg
// Shared types and constants for the DFP SRAM responder.
//   dfp_state_t : responder FSM states
//   dfp_kind_t  : kind of transaction latched on the address beat
//   DFP_POISON  : read data returned for out-of-range addresses when
//                 bounds checking is built in
package dfp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACK_A,
    WDATA,
    ACK_D,
    RWAIT,
    RESP
  } dfp_state_t;

  typedef enum logic {
    KIND_READ,
    KIND_WRITE
  } dfp_kind_t;

  localparam logic [31:0] DFP_POISON = 32'hDEAD_BEEF;

endpackage

// File: rtl/dfp_sram_array.sv
// dfp_sram_array
// Single-port 1RW synchronous SRAM, 32-bit words, one-cycle read latency.
// Behavioral array for simulation; a synthesis build swaps in a macro wrapper
// with the same ports.
// Ports:
//   clk   in   clock
//   en    in   access enable (read or write this cycle)
//   we    in   write enable, qualified by en
//   addr  in   word address
//   wdata in   write data
//   rdata out  read data, valid the cycle after a read access; holds otherwise
module dfp_sram_array #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents and the read register are intentionally not reset, like a real macro.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dfp_sram_responder.sv
// dfp_sram_responder
// DFP memory-interface responder backed by an on-chip word-addressed SRAM.
// Serves one transaction at a time: address beat, then either a write data
// beat or a read response after LATENCY cycles.
// Optional feature macro: DFP_RESP_BOUNDS_EN
//   defined   : out-of-range word indices set sticky err, reads return
//               DFP_POISON, writes are acked but dropped
//   undefined : word index wraps modulo DEPTH_WORDS, err tied 0
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   dfp_read  in   read request, held until acked
//   dfp_write in   write request / write data beat, held until acked
//   dfp_wdata in   byte address on address beat, store data on data beat
//   dfp_ack   out  one-cycle beat accept (registered)
//   dfp_resp  out  one-cycle read data valid (registered)
//   dfp_rdata out  read data, zero outside dfp_resp
//   err       out  sticky out-of-range flag
module dfp_sram_responder
  import dfp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dfp_read,
  input  logic        dfp_write,
  input  logic [31:0] dfp_wdata,
  output logic        dfp_ack,
  output logic        dfp_resp,
  output logic [31:0] dfp_rdata,
  output logic        err
);

  localparam int          AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  dfp_state_t  state;
  dfp_state_t  next_state;
  dfp_kind_t   kind;
  logic [31:0] addr_q;
  logic [3:0]  wait_cnt;
  logic [31:0] offset;
  logic        oob;
  logic [31:0] read_word;
  logic        sram_en;
  logic        sram_we;
  logic [31:0] sram_rdata;

  // Subtraction underflows for addresses below BASE_ADDR, which lands them
  // far above DEPTH_WORDS so the bounds check catches them too.
  assign offset = addr_q - BASE_ADDR;

`ifdef DFP_RESP_BOUNDS_EN
  logic [29:0] word_idx;
  logic        unused_bits;
  logic        err_q;

  assign word_idx    = offset[31:2];
  assign oob         = ({2'b00, word_idx} >= 32'(DEPTH_WORDS));
  assign read_word   = oob ? DFP_POISON : sram_rdata;
  assign unused_bits = ^offset[1:0];
  assign err         = err_q;

  // Sticky flag: set when an out-of-range transaction is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == ACK_A && oob) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_bits;

  assign oob         = 1'b0;
  assign read_word   = sram_rdata;
  assign unused_bits = ^{offset[31:AW+2], offset[1:0]};
  assign err         = 1'b0;
`endif

  dfp_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_sram (
    .clk  (clk),
    .en   (sram_en),
    .we   (sram_we),
    .addr (offset[AW+1:2]),
    .wdata(dfp_wdata),
    .rdata(sram_rdata)
  );

  // Next-state and SRAM strobes. The read is issued in ACK_A so the SRAM's
  // own cycle is part of the LATENCY wait; the write lands at the end of
  // WDATA. Reset suppresses the SRAM strobes so a partial write never lands.
  always_comb begin
    next_state = state;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    case (state)
      IDLE: begin
        if (dfp_read || dfp_write) begin
          next_state = ACK_A;
        end
      end
      ACK_A: begin
        if (kind == KIND_WRITE) begin
          next_state = WDATA;
        end else begin
          next_state = RWAIT;
          sram_en    = 1'b1;
        end
      end
      WDATA: begin
        if (dfp_write) begin
          next_state = ACK_D;
          sram_en    = !oob;
          sram_we    = !oob;
        end
      end
      ACK_D:   next_state = IDLE;
      RWAIT: begin
        if (wait_cnt == 4'd0) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (rst) begin
      sram_en = 1'b0;
      sram_we = 1'b0;
    end
  end

  // State, transaction context, wait counter and registered outputs.
  // Outputs are computed from next_state so each is a plain flop.
  // Read wins when both requests are present; the write stays pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      kind      <= KIND_READ;
      addr_q    <= '0;
      wait_cnt  <= '0;
      dfp_ack   <= 1'b0;
      dfp_resp  <= 1'b0;
      dfp_rdata <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && (dfp_read || dfp_write)) begin
        addr_q <= dfp_wdata;
        kind   <= dfp_read ? KIND_READ : KIND_WRITE;
      end
      if (state == ACK_A) begin
        wait_cnt <= LAT_M1;
      end else if (state == RWAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      dfp_ack   <= (next_state == ACK_A) || (next_state == ACK_D);
      dfp_resp  <= (next_state == RESP);
      dfp_rdata <= (next_state == RESP) ? read_word : 32'h0;
    end
  end

endmodule
